// File: rtl/store_buffer.sv
// store_buffer: write-back store FIFO in front of data_mem.
// Stores are queued and drained into memory on cycles without a load.
// Loads see buffered stores through youngest-match forwarding.
module store_buffer #(
  parameter int DATA  = 32,
  parameter int ADDR  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     st_valid,
  input  logic [ADDR-1:0]          st_addr,
  input  logic [DATA-1:0]          st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR-1:0]          ld_addr,
  output logic [DATA-1:0]          ld_data,
  output logic                     ld_hit,
  output logic                     mem_WE,
  output logic [ADDR-1:0]          mem_A,
  output logic [DATA-1:0]          mem_WD,
  input  logic [DATA-1:0]          mem_RD,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR-1:0] ent_addr [DEPTH];
  logic [DATA-1:0] ent_data [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            enq;
  logic            drain;
  logic            fwd_hit;
  logic [DATA-1:0] fwd_data;

  assign st_ready = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign enq      = st_valid && st_ready;
  assign drain    = !ld_valid && !empty;

  // Memory port arbitration: a load owns the port, otherwise drain the head entry.
  always_comb begin
    mem_WE = 1'b0;
    mem_A  = '0;
    mem_WD = '0;
    if (ld_valid) begin
      mem_A = ld_addr;
    end else if (!empty) begin
      mem_WE = 1'b1;
      mem_A  = ent_addr[head];
      mem_WD = ent_data[head];
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (ent_addr[idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  // Load result mux: buffered data on a match, memory otherwise.
  always_comb begin
    ld_hit  = ld_valid && fwd_hit;
    ld_data = fwd_hit ? fwd_data : mem_RD;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      if (enq && !drain)      count <= count + CW'(1);
      else if (drain && !enq) count <= count - CW'(1);
    end
  end

  // Entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: random and directed stimulus against a queue-based model
// of the store buffer plus a behavioural data_mem.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_ready;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data;
  logic        ld_hit;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic [2:0]  count;
  logic        empty;

  store_buffer #(.DATA(32), .ADDR(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
    .mem_WE(mem_we), .mem_A(mem_a), .mem_WD(mem_wd), .mem_RD(mem_rd),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Behavioural data_mem driven by the DUT.
  logic [31:0] mem [256];
  assign mem_rd = mem[mem_a[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

  // Reference model: program-order queue of pending stores and expected memory.
  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] ref_mem [256];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, update model.
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic lv, input logic [31:0] la, output logic acc);
    int   sz;
    logic hit;
    logic [31:0] hd;
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
    #1;
    sz = q.size();
    check("st_ready", st_ready, sz < DEPTH);
    check("count", count, sz);
    check("empty", empty, sz == 0);
    check("mem_we", mem_we, !lv && sz > 0);
    if (lv) check("mem_a_ld", mem_a, la);
    else if (sz > 0) begin
      check("mem_a_drain", mem_a, q[0].a);
      check("mem_wd_drain", mem_wd, q[0].d);
    end else begin
      check("mem_a_idle", mem_a, 0);
      check("mem_wd_idle", mem_wd, 0);
    end
    hit = 1'b0; hd = '0;
    for (int j = sz - 1; j >= 0; j--) begin
      if (!hit && q[j].a == la) begin hit = 1'b1; hd = q[j].d; end
    end
    check("ld_hit", ld_hit, lv && hit);
    if (lv) check("ld_data", ld_data, hit ? hd : ref_mem[la[7:0]]);
    @(posedge clk);
    if (!lv && sz > 0) begin
      ref_mem[q[0].a[7:0]] = q[0].d;
      void'(q.pop_front());
    end
    acc = sv && (sz < DEPTH);
    if (acc) q.push_back('{a: sa, d: sd});
  endtask

  task automatic drain_all();
    logic acc;
    for (int k = 0; k < 4 * DEPTH && q.size() > 0; k++) step(0, 0, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, acc);
  endtask

  initial begin
    logic acc;
    int   tries;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    // Reset, released on a negedge.
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    step(0, 0, 0, 0, 0, acc);

    // Single store into an empty buffer drains on the next cycle.
    step(1, 8, 15, 0, 0, acc);
    drain_all();
    check("mem8", mem[8], 15);

    // Fill while loads hold the port; the fifth store waits.
    for (int i = 0; i < 4; i++) step(1, 4 * (i + 1), 100 + i, 1, 0, acc);
    for (int i = 0; i < 3; i++) step(1, 20, 104, 1, 0, acc);
    tries = 0;
    do begin step(1, 20, 104, 0, 0, acc); tries++; end while (!acc && tries < 8);
    check("fifth_accept_bounded", tries < 8, 1);
    drain_all();

    // Forwarding: youngest duplicate wins; a miss reads memory.
    step(1, 8, 32'h11, 1, 0, acc);
    step(1, 8, 32'h22, 1, 0, acc);
    step(0, 0, 0, 1, 8, acc);
    step(0, 0, 0, 1, 12, acc);
    drain_all();
    check("mem8_youngest", mem[8], 32'h22);

    // Store/drain pairs to walk the pointers around several times.
    for (int i = 0; i < 10; i++) begin
      step(1, $urandom_range(0, 255), $urandom_range(0, 100), 0, 0, acc);
      step(0, 0, 0, 0, 0, acc);
    end

    // Same-cycle store and load: the new store is not visible yet.
    drain_all();
    step(1, 16, 7, 1, 16, acc);
    step(0, 0, 0, 1, 16, acc);
    drain_all();

    // Random mix over a small address set to exercise hits and duplicates.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1), $urandom_range(0, 7) * 4, $urandom,
           ($urandom_range(0, 2) == 0), $urandom_range(0, 8) * 4, acc);
    drain_all();

    // Reset mid-drain with three entries pending at fresh addresses.
    for (int i = 0; i < 3; i++) step(1, 200 + i, 32'hA0 + i, 1, 0, acc);
    @(negedge clk);
    st_valid = 1'b0; ld_valid = 1'b0;
    #1;
    check("pre_rst_count", count, 3);
    check("pre_rst_we", mem_we, 1);
    #2 rstn = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_we", mem_we, 0);
    check("rst_empty", empty, 1);
    check("rst_ready", st_ready, 1);
    check("rst_hit", ld_hit, 0);
    q.delete();
    @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    repeat (DEPTH + 2) step(0, 0, 0, 0, 0, acc);

    // Memory must match the model everywhere, including untouched 200..202.
    for (int i = 0; i < 256; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-back store queue between the datapath and `data_mem`. It accepts `sw` stores from the single-cycle core into a FIFO and drains them into `data_mem` on cycles when the core does not need the memory port for a load. Loads are forwarded from the youngest matching buffered store, so the core always reads its own writes. It drives `data_mem`'s `WE`, `A` and `WD` directly and receives its `RD`.

## Interface
- `DATA`, 32, data word width
- `ADDR`, 32, address width
- `DEPTH`, 4, number of buffer entries; a power of two, ≥ 2
- `clk`  in  1  system clock; all state updates on its rising edge
- `rstn`  in  1  reset; asynchronous, active-low
- `st_valid`  in  1  core issues a store this cycle
- `st_addr`  in  ADDR  store address
- `st_data`  in  DATA  store data
- `st_ready`  out  1  buffer can accept a store (not full); the core stalls when low
- `ld_valid`  in  1  core issues a load this cycle
- `ld_addr`  in  ADDR  load address
- `ld_data`  out  DATA  load result (forwarded or from memory)
- `ld_hit`  out  1  `ld_data` comes from the buffer
- `mem_WE`  out  1  to `data_mem` `WE`
- `mem_A`  out  ADDR  to `data_mem` `A`
- `mem_WD`  out  DATA  to `data_mem` `WD`
- `mem_RD`  in  DATA  from `data_mem` `RD`
- `count`  out  $clog2(DEPTH)+1  number of valid entries
- `empty`  out  1  `count == 0`

## Operation
- Circular FIFO with `head` (oldest), `tail` (next free) and `count` registers. Each entry holds an address and a data word.
- **Enqueue:** when `st_valid && st_ready`, write `{st_addr, st_data}` at `tail`; `tail` advances modulo DEPTH.
- **st_ready** = `count != DEPTH`. It does not account for a same-cycle drain.
  - When the buffer is full, a store waits for at least one cycle even if a drain occurs that cycle.
  - When `st_valid && !st_ready`, the store is ignored; the core must hold it.
- **Port arbitration:** loads have priority.
  - When `ld_valid` is high: `mem_A = ld_addr`, `mem_WE = 0`, no drain.
  - Otherwise, when `!empty`: `mem_A = head.addr`, `mem_WD = head.data`, `mem_WE = 1`, and `head` advances modulo DEPTH at the clock edge.
  - Otherwise: `mem_WE = 0`, `mem_A = 0`, `mem_WD = 0`.
- **Forwarding:** `ld_addr` is compared (full ADDR bits) against every valid entry.
  - On any match, `ld_hit = ld_valid`, and `ld_data` is the data of the youngest matching entry (closest to `tail`).
  - With no match, `ld_hit = 0` and `ld_data = mem_RD`.
  - A store being enqueued in the same cycle is not visible to that cycle's load.
- **count update:** `+1` on enqueue only, `−1` on drain only, unchanged when both or neither occur.
- **Simultaneous `st_valid` and `ld_valid`:** both are serviced. The store enqueues and the load is arbitrated/forwarded against the pre-enqueue contents.
- **Duplicate addresses:** entries are never merged. Each store drains in program order, so memory ends with the youngest value.

## Timing
- **Reset** (`rstn` low, asynchronous): `head = tail = count = 0`. Outputs go to `empty = 1`, `st_ready = 1`, `mem_WE = 0`, `mem_A = 0`, `mem_WD = 0`, `ld_hit = 0`, `ld_data = mem_RD`.
  - Entries stored before reset are discarded and never written to memory.
  - Entry storage need not be reset.
- **Combinational outputs:** `mem_WE`, `mem_A`, `mem_WD`, `ld_hit` and `ld_data` depend only on current state and inputs; there is no registered output stage.
- **Latency:**
  - A store accepted at edge N is drained no earlier than cycle N+1. Into an empty buffer with no loads, `mem_WE` is high in cycle N+1 and memory is updated at edge N+2.
  - Load forwarding has zero cycles of latency.
- **Drain rate:** at most one entry per cycle. With no loads, a full buffer drains in DEPTH cycles.
- **Wrap-around:** `head` and `tail` wrap from DEPTH−1 to 0; `count` distinguishes full from empty.

## Test plan
- **Reset checks:** assert reset, then release on a negedge → `count = 0`, `empty = 1`, `st_ready = 1`, `mem_WE = 0`. Then store `(A=8, WD=15)` with no loads → `mem_WE = 1`, `mem_A = 8`, `mem_WD = 15` in the next cycle, and `data_mem[8] = 15` afterwards.
- **Fill and drain:** hold `ld_valid = 1` (`ld_addr = 0`) and issue 5 stores to A = 4, 8, 12, 16, 20.
  - The first 4 are accepted; `st_ready = 0` and `count = 4`; the 5th is held.
  - Release `ld_valid` → the 5th store is accepted one cycle after the first drain, and memory is written in FIFO order.
- **Forwarding:** with `ld_valid` held, store `(8, 0x11)` then `(8, 0x22)`, then load from 8 → `ld_hit = 1`, `ld_data = 0x22`. Load from 12 → `ld_hit = 0`, `ld_data = mem_RD`.
- **Wrap-around:** 10 store/drain pairs with random A in 0–255 and WD in 0–100 → pointers wrap, and every value lands in memory in issue order (checked against a reference model).
- **Same-cycle store and load:** store `(16, 7)` and load from 16 in the same cycle, with 16 not already buffered → `ld_hit = 0`. The following cycle's load from 16 → `ld_hit = 1`, `ld_data = 7`.
- **Reset mid-drain:** assert `rstn = 0` with `count = 3` → `count = 0` and `mem_WE = 0` immediately (asynchronously), and none of the remaining entries ever reach memory.
